// File: rtl/alu_mdu_control_if.sv
// ============================================================================
//  Module      : alu_mdu_control_if
//  Description : Bundle between the control unit, instruction bus, ALU and MDU
//                on one side and the ALU/MDU control block on the other.
//                slave  - the control block (consumes decode fields, drives
//                         ALU operation and MDU sequencing outputs)
//                master - the surrounding pipeline / testbench
//  Signals     : valid_i, funct7_i[6:0], ALU_Op_i[2:0], funct3_i[2:0],
//                mdu_done_i                                   (to block)
//                ALU_Operation_o[OP_W-1:0], mdu_start_o, mdu_op_o[2:0],
//                stall_o, mdu_result_sel_o, mdu_timeout_o,
//                illegal_o                                    (from block)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_mdu_control_if #(
   parameter int OP_W = 4
);
   logic             valid_i;
   logic [6:0]       funct7_i;
   logic [2:0]       ALU_Op_i;
   logic [2:0]       funct3_i;
   logic             mdu_done_i;
   logic [OP_W-1:0]  ALU_Operation_o;
   logic             mdu_start_o;
   logic [2:0]       mdu_op_o;
   logic             stall_o;
   logic             mdu_result_sel_o;
   logic             mdu_timeout_o;
   logic             illegal_o;

   modport slave (
      input  valid_i, funct7_i, ALU_Op_i, funct3_i, mdu_done_i,
      output ALU_Operation_o, mdu_start_o, mdu_op_o, stall_o,
             mdu_result_sel_o, mdu_timeout_o, illegal_o
   );

   modport master (
      output valid_i, funct7_i, ALU_Op_i, funct3_i, mdu_done_i,
      input  ALU_Operation_o, mdu_start_o, mdu_op_o, stall_o,
             mdu_result_sel_o, mdu_timeout_o, illegal_o
   );
endinterface

`default_nettype wire

// File: rtl/alu_mdu_control.sv
// ============================================================================
//  Module      : alu_mdu_control
//  Description : RV32 ALU control. Decodes {funct7, ALU_Op, funct3} into a
//                4-bit ALU operation for all RV32I forms and sequences the
//                multi-cycle M-extension unit (start, stall, done, timeout).
//  Ports       : clk    - core clock, rising edge
//                reset  - asynchronous, active-low
//                bus    - alu_mdu_control_if.slave (decode fields in,
//                         ALU operation / MDU control / illegal out)
//  Parameters  : OP_W (ALU op width), MDU_TIMEOUT (BUSY cycles before abort),
//                CNT_W (busy counter width, holds MDU_TIMEOUT-1)
//  Config      : RV_M_EXT_EN defined  -> M-extension decode and MDU sequencer
//                RV_M_EXT_EN undefined -> MDU outputs tied low, M encodings
//                                         are reported illegal
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu_control #(
   parameter int OP_W        = 4,
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  wire logic            clk,
   input  wire logic            reset,
   alu_mdu_control_if.slave     bus
);

   localparam logic [OP_W-1:0] c_ADD    = OP_W'(4'h0);
   localparam logic [OP_W-1:0] c_SUB    = OP_W'(4'h1);
   localparam logic [OP_W-1:0] c_SLL    = OP_W'(4'h2);
   localparam logic [OP_W-1:0] c_SLT    = OP_W'(4'h3);
   localparam logic [OP_W-1:0] c_SLTU   = OP_W'(4'h4);
   localparam logic [OP_W-1:0] c_XOR    = OP_W'(4'h5);
   localparam logic [OP_W-1:0] c_SRL    = OP_W'(4'h6);
   localparam logic [OP_W-1:0] c_SRA    = OP_W'(4'h7);
   localparam logic [OP_W-1:0] c_OR     = OP_W'(4'h8);
   localparam logic [OP_W-1:0] c_AND    = OP_W'(4'h9);
   localparam logic [OP_W-1:0] c_PASS_B = OP_W'(4'hA);

   localparam logic [6:0] c_F7_BASE = 7'b0000000;
   localparam logic [6:0] c_F7_ALT  = 7'b0100000;
   localparam logic [6:0] c_F7_MULD = 7'b0000001;

   logic [OP_W-1:0] w_f3_op;
   logic [OP_W-1:0] w_op;
   logic            w_ill;
   logic            w_m_enc;

   // Plain funct3 mapping shared by R-type and I-type arithmetic.
   always_comb begin
      w_f3_op = c_ADD;
      case (bus.funct3_i)
         3'b000:  w_f3_op = c_ADD;
         3'b001:  w_f3_op = c_SLL;
         3'b010:  w_f3_op = c_SLT;
         3'b011:  w_f3_op = c_SLTU;
         3'b100:  w_f3_op = c_XOR;
         3'b101:  w_f3_op = c_SRL;
         3'b110:  w_f3_op = c_OR;
         default: w_f3_op = c_AND;
      endcase
   end

   assign w_m_enc = (bus.ALU_Op_i == 3'b000) && (bus.funct7_i == c_F7_MULD);

   // Every unsupported encoding falls back to ADD and flags w_ill.
   always_comb begin
      w_op  = c_ADD;
      w_ill = 1'b0;
      case (bus.ALU_Op_i)
         3'b000: begin
            if (bus.funct7_i == c_F7_BASE) begin
               w_op = w_f3_op;
            end else if (bus.funct7_i == c_F7_ALT) begin
               if (bus.funct3_i == 3'b000)      w_op  = c_SUB;
               else if (bus.funct3_i == 3'b101) w_op  = c_SRA;
               else                             w_ill = 1'b1;
            end else if (w_m_enc) begin
`ifdef RV_M_EXT_EN
               w_op  = c_ADD;
`else
               w_ill = 1'b1;
`endif
            end else begin
               w_ill = 1'b1;
            end
         end
         3'b001: begin
            // Only the shift forms look at funct7.
            if (bus.funct3_i == 3'b001) begin
               if (bus.funct7_i == c_F7_BASE) w_op  = c_SLL;
               else                           w_ill = 1'b1;
            end else if (bus.funct3_i == 3'b101) begin
               if (bus.funct7_i == c_F7_BASE)     w_op  = c_SRL;
               else if (bus.funct7_i == c_F7_ALT) w_op  = c_SRA;
               else                               w_ill = 1'b1;
            end else begin
               w_op = w_f3_op;
            end
         end
         3'b010:  w_op = c_ADD;
         3'b011: begin
            case (bus.funct3_i)
               3'b000, 3'b001: w_op  = c_SUB;
               3'b100, 3'b101: w_op  = c_SLT;
               3'b110, 3'b111: w_op  = c_SLTU;
               default:        w_ill = 1'b1;
            endcase
         end
         3'b100:  w_op  = c_PASS_B;
         3'b101:  w_op  = c_ADD;
         default: w_ill = 1'b1;
      endcase
   end

   assign bus.ALU_Operation_o = w_op;
   assign bus.illegal_o       = bus.valid_i & w_ill;

`ifdef RV_M_EXT_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_start;
   logic [2:0]       r_op;
   logic             r_sel;
   logic             r_tmo;
   logic             w_launch;

   assign w_launch = bus.valid_i & w_m_enc;

   // Pulse outputs default low each cycle; mdu_done_i outside BUSY is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_start <= 1'b0;
         r_op    <= 3'b000;
         r_sel   <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_sel   <= 1'b0;
         r_tmo   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_state <= S_BUSY;
                  r_start <= 1'b1;
                  r_op    <= bus.funct3_i;
                  r_cnt   <= '0;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               // A done arriving on the last allowed cycle beats the timeout.
               if (bus.mdu_done_i) begin
                  r_state <= S_DONE;
                  r_sel   <= 1'b1;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_state <= S_DONE;
                  r_sel   <= 1'b1;
                  r_tmo   <= 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stall starts in the decode cycle itself and drops in DONE so the
   // M instruction retires together with the MDU result.
   assign bus.stall_o          = ((r_state == S_IDLE) & w_launch) | (r_state == S_BUSY);
   assign bus.mdu_start_o      = r_start;
   assign bus.mdu_op_o         = r_op;
   assign bus.mdu_result_sel_o = r_sel;
   assign bus.mdu_timeout_o    = r_tmo;
`else
   localparam int c_unused_cfg = MDU_TIMEOUT + CNT_W;
   logic w_unused_in;
   assign w_unused_in = bus.mdu_done_i ^ clk ^ reset ^ (c_unused_cfg != 0);

   assign bus.stall_o          = 1'b0;
   assign bus.mdu_start_o      = 1'b0;
   assign bus.mdu_op_o         = 3'b000;
   assign bus.mdu_result_sel_o = 1'b0;
   assign bus.mdu_timeout_o    = 1'b0;
`endif

endmodule

`default_nettype wire
